opb_reg_slot_arbiter: RTL
=========================

// Module: opb_reg_slot_arbiter
// PURPOSE
//  Single OPB slave front-end for a bank of simulink2ppc-style software registers.
//  Decodes the OPB address into one of C_NUM_SLOTS 256-byte slots, forwards select to that slot,
//  waits for its ack under a timeout, and returns data/ack to the master.
//  Sits between the OPB bus and the per-register slaves (loopback/rx counters, status words).
//  Out-of-range accesses and stuck slaves terminate with errAck instead of hanging the bus.
// PARAMETERS
//  C_BASEADDR   32'h01008000  first byte address of slot 0
//  C_NUM_SLOTS  8             number of register slots (1..16)
//  C_SLOT_AW    8             log2 of slot size in bytes (256-byte slots)
//  C_TIMEOUT    16            max cycles in WAIT before errAck (>=2)
// PORTS
//  OPB_Clk      in   1      bus clock; the only clock
//  OPB_Rst      in   1      synchronous, active-high reset
//  OPB_ABus     in   [0:31] address
//  OPB_BE       in   [0:3]  byte enables, forwarded unchanged
//  OPB_DBus     in   [0:31] write data, forwarded unchanged
//  OPB_RNW      in   1      1=read
//  OPB_select   in   1      master select
//  OPB_seqAddr  in   1      ignored (no burst support)
//  Sl_DBus      out  [0:31] read data; zero except in the Sl_xferAck cycle of a read
//  Sl_xferAck   out  1      transfer ack, 1-cycle pulse
//  Sl_errAck    out  1      error ack, 1-cycle pulse coincident with Sl_xferAck
//  Sl_retry     out  1      tied 0
//  Sl_toutSup   out  1      high while in DECODE/WAIT
//  slot_select  out  C_NUM_SLOTS  one-hot select to the addressed slot
//  slot_xferAck in   C_NUM_SLOTS  per-slot ack
//  slot_DBus    in   32*C_NUM_SLOTS  per-slot read data, slot i at [32*i+:32]
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-transfer drops slot_select in the next cycle, no ack issued.
//  FSM IDLE->DECODE->{WAIT|ERR}; WAIT->{DONE|ERR|IDLE}; DONE->RECOVER; ERR->RECOVER; RECOVER->IDLE.
//  IDLE: OPB_select=1 -> DECODE; register offset = OPB_ABus - C_BASEADDR.
//  DECODE: hit = offset < C_NUM_SLOTS<<C_SLOT_AW (unsigned 32-bit compare; ABus<base wraps -> miss).
//   idx = offset>>C_SLOT_AW. hit -> WAIT with slot_select[idx]=1 registered; miss -> ERR.
//  WAIT: slot_select held; counter increments each cycle.
//   slot_xferAck[idx]=1 -> DONE; latch slot_DBus[idx] if RNW=1, else latch 0.
//   Acks from non-selected slots ignored. Ack and timeout in same cycle: ack wins.
//   counter==C_TIMEOUT-1 with no ack -> ERR. OPB_select=0 (abort) -> IDLE, no ack, select dropped.
//  DONE: Sl_xferAck=1 for one cycle with latched Sl_DBus; slot_select=0.
//  ERR: Sl_xferAck=1 and Sl_errAck=1 for one cycle; Sl_DBus=0; slot_select=0.
//  RECOVER: one cycle, OPB_select ignored (master releases select after ack).
//  Latency (hit, slave acks k>=0 cycles after slot_select rises): select seen at cycle 0,
//   slot_select at cycle 2, Sl_xferAck at cycle 3+k. Miss: Sl_errAck at cycle 2.
//  All outputs registered; no combinational path OPB_* -> Sl_*.
// STRUCTURE
//  Package opb_slot_pkg: state enum (IDLE, DECODE, WAIT, DONE, ERR, RECOVER), OPB_DW=32,
//   slot index width function clog2(C_NUM_SLOTS).
//  Sub-module opb_slot_decode: combinational base/range check -> hit, idx.
//  Top holds FSM, timeout counter, data latch, output registers.
// TESTING
//  1 Read 0x01008200 (slot 2), slot 2 acks 3 cycles after select with 0xDEADBEEF
//    -> slot_select=8'h04 at cycle 2, Sl_xferAck+Sl_DBus=0xDEADBEEF at cycle 6, Sl_DBus=0 after.
//  2 Write 0x01008704 (slot 7), ack k=0 -> Sl_xferAck cycle 3, Sl_DBus=0, Sl_errAck=0.
//  3 Read 0x01009000 and 0x01007FFC -> Sl_errAck+Sl_xferAck at cycle 2, slot_select never set.
//  4 Read slot 0, no ack, C_TIMEOUT=16 -> errAck pulse after 16 WAIT cycles, slot_select low next.
//  5 Slot 3 selected, slot 5 acks, then OPB_select drops -> no Sl_xferAck, IDLE, selects 0.
//  6 OPB_Rst asserted in WAIT -> all outputs 0 next cycle; new read after reset completes normally.

Source files
------------

// File: rtl/opb_slot_pkg.sv
// Shared types and helpers for the OPB register-slot arbiter.
package opb_slot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT,
        DONE,
        ERR,
        RECOVER
    } opb_state_t;

    localparam int OPB_DW = 32;

    // Index width for a slot count; never narrower than one bit.
    function automatic int slot_iw(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/opb_slot_decode.sv
// Range check of a base-relative offset against the slot window; yields hit and slot index.
module opb_slot_decode
    import opb_slot_pkg::*;
#(
    parameter int C_NUM_SLOTS = 8,
    parameter int C_SLOT_AW   = 8,
    parameter int IW          = slot_iw(C_NUM_SLOTS)
) (
    input  logic [31:0]   offset,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Addresses below the base wrap to huge offsets and therefore miss.
    localparam logic [32:0] SPAN = 33'(C_NUM_SLOTS) << C_SLOT_AW;

    logic [31:0] slot_num;

    assign slot_num = offset >> C_SLOT_AW;
    assign hit      = ({1'b0, offset} < SPAN);
    assign idx      = slot_num[IW-1:0];

endmodule

// File: rtl/opb_reg_slot_arbiter.sv
// OPB slave front-end: routes each access to one of C_NUM_SLOTS register slots, with timeout/errAck.
module opb_reg_slot_arbiter
    import opb_slot_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR  = 32'h01008000,
    parameter int          C_NUM_SLOTS = 8,
    parameter int          C_SLOT_AW   = 8,
    parameter int          C_TIMEOUT   = 16
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst,
    input  logic [0:31]                   OPB_ABus,
    input  logic [0:3]                    OPB_BE,
    input  logic [0:31]                   OPB_DBus,
    input  logic                          OPB_RNW,
    input  logic                          OPB_select,
    input  logic                          OPB_seqAddr,
    output logic [0:31]                   Sl_DBus,
    output logic                          Sl_xferAck,
    output logic                          Sl_errAck,
    output logic                          Sl_retry,
    output logic                          Sl_toutSup,
    output logic [C_NUM_SLOTS-1:0]        slot_select,
    input  logic [C_NUM_SLOTS-1:0]        slot_xferAck,
    input  logic [OPB_DW*C_NUM_SLOTS-1:0] slot_DBus
);

    localparam int IW = slot_iw(C_NUM_SLOTS);
    localparam int CW = $clog2(C_TIMEOUT) + 1;
    localparam logic [C_NUM_SLOTS-1:0] SEL_ONE = 1;

    opb_state_t              state_reg;
    logic [31:0]             offset_reg;
    logic                    rnw_reg;
    logic [IW-1:0]           idx_reg;
    logic [CW-1:0]           count_reg;
    logic [C_NUM_SLOTS-1:0]  sel_reg;
    logic [OPB_DW-1:0]       dbus_reg;
    logic                    xfer_ack_reg;
    logic                    err_ack_reg;
    logic                    tout_sup_reg;

    logic                    dec_hit;
    logic [IW-1:0]           dec_idx;
    logic                    slot_ack;
    logic [OPB_DW-1:0]       slot_word [C_NUM_SLOTS];

    // Byte enables and write data go to slaves on their own wiring; no bursts.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, OPB_seqAddr, OPB_BE, OPB_DBus};

    opb_slot_decode #(
        .C_NUM_SLOTS (C_NUM_SLOTS),
        .C_SLOT_AW   (C_SLOT_AW),
        .IW          (IW)
    ) u_decode (
        .offset (offset_reg),
        .hit    (dec_hit),
        .idx    (dec_idx)
    );

    generate
        for (genvar gi = 0; gi < C_NUM_SLOTS; gi++) begin : g_slot_word
            assign slot_word[gi] = slot_DBus[OPB_DW*gi +: OPB_DW];
        end
    endgenerate

    // Only the slot we selected may complete the transfer.
    assign slot_ack = slot_xferAck[idx_reg];

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_reg    <= IDLE;
            offset_reg   <= '0;
            rnw_reg      <= 1'b0;
            idx_reg      <= '0;
            count_reg    <= '0;
            sel_reg      <= '0;
            dbus_reg     <= '0;
            xfer_ack_reg <= 1'b0;
            err_ack_reg  <= 1'b0;
            tout_sup_reg <= 1'b0;
        end else begin
            xfer_ack_reg <= 1'b0;
            err_ack_reg  <= 1'b0;
            dbus_reg     <= '0;
            case (state_reg)
                IDLE: begin
                    if (OPB_select) begin
                        state_reg    <= DECODE;
                        offset_reg   <= OPB_ABus - C_BASEADDR;
                        rnw_reg      <= OPB_RNW;
                        tout_sup_reg <= 1'b1;
                    end
                end
                DECODE: begin
                    count_reg <= '0;
                    if (dec_hit) begin
                        state_reg <= WAIT;
                        idx_reg   <= dec_idx;
                        sel_reg   <= SEL_ONE << dec_idx;
                    end else begin
                        state_reg    <= ERR;
                        xfer_ack_reg <= 1'b1;
                        err_ack_reg  <= 1'b1;
                        tout_sup_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    count_reg <= count_reg + 1'b1;
                    // A master that has already let go gets no ack, even from a late slave.
                    if (!OPB_select) begin
                        state_reg    <= IDLE;
                        sel_reg      <= '0;
                        tout_sup_reg <= 1'b0;
                    end else if (slot_ack) begin
                        state_reg    <= DONE;
                        sel_reg      <= '0;
                        xfer_ack_reg <= 1'b1;
                        dbus_reg     <= rnw_reg ? slot_word[idx_reg] : '0;
                        tout_sup_reg <= 1'b0;
                    end else if (count_reg == CW'(C_TIMEOUT - 1)) begin
                        state_reg    <= ERR;
                        sel_reg      <= '0;
                        xfer_ack_reg <= 1'b1;
                        err_ack_reg  <= 1'b1;
                        tout_sup_reg <= 1'b0;
                    end
                end
                DONE:    state_reg <= RECOVER;
                ERR:     state_reg <= RECOVER;
                RECOVER: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Sl_DBus     = dbus_reg;
    assign Sl_xferAck  = xfer_ack_reg;
    assign Sl_errAck   = err_ack_reg;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = tout_sup_reg;
    assign slot_select = sel_reg;

endmodule
